// File: rtl/uart_rxfsm_gen2.sv
// UART receive engine on the OSR-times baud clock: majority-of-3 sampling,
// run-time length/parity/stop, break and idle-timeout detection.
module uart_rxfsm_gen2 #(
    parameter int unsigned OSR    = 16,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned TOUT_W = 8
) (
    input  logic              baud_clk_16x,
    input  logic              reset,
    input  logic              cfg_rx_enable,
    input  logic [3:0]        cfg_data_len,
    input  logic              cfg_stop_bit,
    input  logic [2:0]        cfg_pri_mod,
    input  logic [TOUT_W-1:0] cfg_tout_char,
    input  logic              fifo_aval,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_data,
    output logic [2:0]        fifo_status,
    output logic              rx_ovr,
    output logic              rx_timeout,
    output logic              rx_break,
    input  logic              si
);

    localparam int unsigned PH_W = $clog2(OSR);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_PARITY   = 3'd3;
    localparam logic [2:0] S_STOP1    = 3'd4;
    localparam logic [2:0] S_STOP2    = 3'd5;
    localparam logic [2:0] S_BRK_WAIT = 3'd6;

    logic              r_sync1, r_sync2;
    logic [1:0]        r_hist;
    logic [2:0]        r_state;
    logic [PH_W-1:0]   r_phase;
    logic [3:0]        r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_par_bit;
    logic              r_par_err;
    logic [PH_W-1:0]   r_tmr;
    logic [TOUT_W-1:0] r_tcnt;
    logic              r_armed;
    logic              r_fifo_wr;
    logic [DATA_W-1:0] r_fifo_data;
    logic [2:0]        r_fifo_status;
    logic              r_rx_ovr;
    logic              r_rx_timeout;
    logic              r_rx_break;

    logic [2:0]        w_state;
    logic [PH_W-1:0]   w_phase;
    logic [3:0]        w_idx;
    logic [DATA_W-1:0] w_data;
    logic              w_par_bit;
    logic              w_par_err;
    logic [PH_W-1:0]   w_tmr;
    logic [TOUT_W-1:0] w_tcnt;
    logic              w_armed;
    logic              w_fifo_wr;
    logic [DATA_W-1:0] w_fifo_data;
    logic [2:0]        w_fifo_status;
    logic              w_rx_ovr;
    logic              w_rx_timeout;
    logic              w_rx_break;

    logic [3:0]        w_len;
    logic              w_par_en;
    logic              w_par_exp;
    logic              w_mid;
    logic              w_last_ph;
    logic              w_bit_val;
    logic              w_fall;
    logic              w_wr_req;
    logic              w_brk;
    logic              w_ferr;
    logic              w_tick;
    logic [TOUT_W-1:0] w_tcnt_inc;

    assign fifo_wr     = r_fifo_wr;
    assign fifo_data   = r_fifo_data;
    assign fifo_status = r_fifo_status;
    assign rx_ovr      = r_rx_ovr;
    assign rx_timeout  = r_rx_timeout;
    assign rx_break    = r_rx_break;

    // Pad synchroniser and sample history; only reset clears it, never cfg_rx_enable.
    always_ff @(posedge baud_clk_16x) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 2'b11;
        end else begin
            r_sync1 <= si;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[0], r_sync2};
        end
    end

    always_comb begin
        if (cfg_data_len < 4'd5)
            w_len = 4'd5;
        else if (cfg_data_len > 4'(DATA_W))
            w_len = 4'(DATA_W);
        else
            w_len = cfg_data_len;
    end

    assign w_par_en   = (cfg_pri_mod == 3'b010) || (cfg_pri_mod == 3'b011) ||
                        (cfg_pri_mod == 3'b100) || (cfg_pri_mod == 3'b101);
    // The third of the three vote samples arrives at phase OSR/2+1.
    assign w_mid      = (r_phase == PH_W'(OSR/2 + 1));
    assign w_last_ph  = (r_phase == PH_W'(OSR - 1));
    assign w_bit_val  = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
    assign w_fall     = r_hist[0] & ~r_sync2;
    assign w_tick     = (r_state == S_IDLE) && (r_tmr == PH_W'(OSR - 1));
    assign w_tcnt_inc = (&r_tcnt) ? r_tcnt : r_tcnt + TOUT_W'(1);

    always_comb begin
        case (cfg_pri_mod)
            3'b010:  w_par_exp = ^r_data;
            3'b011:  w_par_exp = ~^r_data;
            3'b100:  w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        w_state       = r_state;
        w_phase       = w_last_ph ? '0 : r_phase + PH_W'(1);
        w_idx         = r_idx;
        w_data        = r_data;
        w_par_bit     = r_par_bit;
        w_par_err     = r_par_err;
        w_wr_req      = 1'b0;
        w_brk         = 1'b0;
        w_ferr        = 1'b0;
        w_fifo_wr     = 1'b0;
        w_fifo_data   = r_fifo_data;
        w_fifo_status = r_fifo_status;
        w_rx_ovr      = 1'b0;
        w_rx_timeout  = 1'b0;
        w_rx_break    = 1'b0;
        w_tmr         = r_tmr;
        w_tcnt        = r_tcnt;
        w_armed       = r_armed;

        case (r_state)
            S_IDLE: begin
                // The edge-detect cycle counts as phase 0 of the start bit.
                w_phase = '0;
                if (w_fall) begin
                    w_state   = S_START;
                    w_phase   = PH_W'(1);
                    w_idx     = '0;
                    w_data    = '0;
                    w_par_bit = 1'b0;
                    w_par_err = 1'b0;
                end
            end
            S_START: begin
                if (w_mid && w_bit_val) begin
                    w_state = S_IDLE;
                end else if (w_last_ph) begin
                    w_state = S_DATA;
                    w_idx   = '0;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_data = r_data | (DATA_W'(w_bit_val) << r_idx);
                    w_idx  = r_idx + 4'd1;
                    if (r_idx == w_len - 4'd1)
                        w_state = w_par_en ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_par_bit = w_bit_val;
                    w_par_err = (w_bit_val != w_par_exp);
                    w_state   = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_mid) begin
                    if (!w_bit_val && (r_data == '0) && !r_par_bit) begin
                        w_brk    = 1'b1;
                        w_ferr   = 1'b1;
                        w_wr_req = 1'b1;
                        w_state  = S_BRK_WAIT;
                    end else if (!w_bit_val) begin
                        w_ferr   = 1'b1;
                        w_wr_req = 1'b1;
                        w_state  = S_IDLE;
                    end else if (cfg_stop_bit) begin
                        w_state  = S_STOP2;
                    end else begin
                        w_wr_req = 1'b1;
                        w_state  = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (w_mid) begin
                    w_ferr   = ~w_bit_val;
                    w_wr_req = 1'b1;
                    w_state  = S_IDLE;
                end
            end
            S_BRK_WAIT: begin
                w_phase = '0;
                if (r_sync2)
                    w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_phase = '0;
            end
        endcase

        // A break reports every error flag alongside the all-zero character.
        if (w_wr_req) begin
            if (fifo_aval) begin
                w_fifo_wr     = 1'b1;
                w_fifo_data   = r_data;
                w_fifo_status = {w_brk, w_brk | r_par_err, w_ferr};
            end else begin
                w_rx_ovr = 1'b1;
            end
        end
        w_rx_break = w_brk;

        if (r_armed && (cfg_tout_char != '0) && w_tick && (w_tcnt_inc == cfg_tout_char)) begin
            w_rx_timeout = 1'b1;
            w_armed      = 1'b0;
        end

        // Idle bit-time counter: runs only while staying in IDLE.
        if (w_fifo_wr) begin
            w_tmr   = '0;
            w_tcnt  = '0;
            w_armed = 1'b1;
        end else if ((r_state != S_IDLE) || (w_state != S_IDLE)) begin
            w_tmr  = '0;
            w_tcnt = '0;
        end else begin
            w_tmr = (r_tmr == PH_W'(OSR - 1)) ? '0 : r_tmr + PH_W'(1);
            if (w_tick)
                w_tcnt = w_tcnt_inc;
        end
    end

    always_ff @(posedge baud_clk_16x) begin
        if (reset || !cfg_rx_enable) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_idx         <= '0;
            r_data        <= '0;
            r_par_bit     <= 1'b0;
            r_par_err     <= 1'b0;
            r_tmr         <= '0;
            r_tcnt        <= '0;
            r_armed       <= 1'b0;
            r_fifo_wr     <= 1'b0;
            r_fifo_data   <= '0;
            r_fifo_status <= '0;
            r_rx_ovr      <= 1'b0;
            r_rx_timeout  <= 1'b0;
            r_rx_break    <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_phase       <= w_phase;
            r_idx         <= w_idx;
            r_data        <= w_data;
            r_par_bit     <= w_par_bit;
            r_par_err     <= w_par_err;
            r_tmr         <= w_tmr;
            r_tcnt        <= w_tcnt;
            r_armed       <= w_armed;
            r_fifo_wr     <= w_fifo_wr;
            r_fifo_data   <= w_fifo_data;
            r_fifo_status <= w_fifo_status;
            r_rx_ovr      <= w_rx_ovr;
            r_rx_timeout  <= w_rx_timeout;
            r_rx_break    <= w_rx_break;
        end
    end

endmodule

// File: tb/tb_uart_rxfsm_gen2.sv
// Directed bench for uart_rxfsm_gen2: hand-built frames, expected values computed here.
module tb_uart_rxfsm_gen2;

    localparam int unsigned OSR    = 16;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned TOUT_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_rx_enable;
    logic [3:0]        cfg_data_len;
    logic              cfg_stop_bit;
    logic [2:0]        cfg_pri_mod;
    logic [TOUT_W-1:0] cfg_tout_char;
    logic              fifo_aval;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_data;
    logic [2:0]        fifo_status;
    logic              rx_ovr;
    logic              rx_timeout;
    logic              rx_break;
    logic              si;

    uart_rxfsm_gen2 #(.OSR(OSR), .DATA_W(DATA_W), .TOUT_W(TOUT_W)) u_dut (
        .baud_clk_16x  (clk),
        .reset         (reset),
        .cfg_rx_enable (cfg_rx_enable),
        .cfg_data_len  (cfg_data_len),
        .cfg_stop_bit  (cfg_stop_bit),
        .cfg_pri_mod   (cfg_pri_mod),
        .cfg_tout_char (cfg_tout_char),
        .fifo_aval     (fifo_aval),
        .fifo_wr       (fifo_wr),
        .fifo_data     (fifo_data),
        .fifo_status   (fifo_status),
        .rx_ovr        (rx_ovr),
        .rx_timeout    (rx_timeout),
        .rx_break      (rx_break),
        .si            (si)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_wr = 0, n_ovr = 0, n_brk = 0, n_tout = 0;
    int wr_cyc = 0, tout_cyc = 0;
    logic [DATA_W-1:0] last_data = '0;
    logic [2:0]        last_status = '0;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (fifo_wr) begin
            n_wr        <= n_wr + 1;
            wr_cyc      <= cyc;
            last_data   <= fifo_data;
            last_status <= fifo_status;
        end
        if (rx_ovr)     n_ovr <= n_ovr + 1;
        if (rx_break)   n_brk <= n_brk + 1;
        if (rx_timeout) begin
            n_tout   <= n_tout + 1;
            tout_cyc <= cyc;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int start_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // pkind: 0 none, 1 even, 2 odd, 3 mark, 4 space
    task automatic make_frame(input logic [8:0] d, input int len, input int pkind, input bit pflip,
                              input int nstop, input bit stop2_low,
                              output logic [15:0] f, output int n);
        logic p;
        f = '1;
        n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < len; i++) begin
            f[n] = d[i]; n++;
        end
        if (pkind != 0) begin
            p = 1'b0;
            for (int i = 0; i < len; i++) p = p ^ d[i];
            case (pkind)
                1: p = p;
                2: p = ~p;
                3: p = 1'b1;
                default: p = 1'b0;
            endcase
            f[n] = p ^ pflip; n++;
        end
        f[n] = 1'b1; n++;
        if (nstop == 2) begin
            f[n] = ~stop2_low; n++;
        end
    endtask

    task automatic send_frame(input logic [15:0] f, input int n, input bit glitch);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < OSR; k++) begin
                @(posedge clk); #1;
                if (b == 0 && k == 0) start_cyc = cyc;
                si = (glitch && k == OSR/2) ? ~f[b] : f[b];
            end
        end
    endtask

    task automatic line(input int ncyc, input logic v);
        repeat (ncyc) begin
            @(posedge clk); #1;
            si = v;
        end
    endtask

    logic [15:0] fr;
    int          fn;
    int          nw;

    initial begin
        reset = 1'b1; cfg_rx_enable = 1'b1; cfg_data_len = 4'd8; cfg_stop_bit = 1'b0;
        cfg_pri_mod = 3'b000; cfg_tout_char = '0; fifo_aval = 1'b1; si = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_fifo_wr", 32'(fifo_wr), 0);
        check_eq("rst_fifo_data", 32'(fifo_data), 0);
        check_eq("rst_status", 32'(fifo_status), 0);
        check_eq("rst_pulses", 32'({rx_ovr, rx_timeout, rx_break}), 0);
        @(posedge clk); #1; reset = 1'b0;
        line(20, 1'b1);

        // 8N1 0xA5; write lands 2 sync cycles + 9*16+8+2 after the pad edge
        make_frame(9'h0A5, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("a5_count", 32'(n_wr), 1);
        check_eq("a5_data", 32'(last_data), 32'h0A5);
        check_eq("a5_status", 32'(last_status), 0);
        check_eq("a5_latency", 32'(wr_cyc - start_cyc), 32'(2 + 9*16 + 8 + 2));

        // 7E2 with wrong parity, then good parity with low second stop
        cfg_data_len = 4'd7; cfg_pri_mod = 3'b010; cfg_stop_bit = 1'b1;
        make_frame(9'h03C, 7, 1, 1, 2, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("7e2_par_data", 32'(last_data), 32'h03C);
        check_eq("7e2_par_status", 32'(last_status), 32'b010);
        make_frame(9'h03C, 7, 1, 0, 2, 1, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("7e2_stop2_status", 32'(last_status), 32'b001);
        check_eq("7e2_count", 32'(n_wr), 3);

        // single-cycle low glitch in idle
        line(1, 1'b0); line(60, 1'b1);
        check_eq("glitch_nowrite", 32'(n_wr), 3);

        // 9-bit mark parity, clean then with a one-sample glitch in each bit
        cfg_data_len = 4'd9; cfg_pri_mod = 3'b100; cfg_stop_bit = 1'b0;
        make_frame(9'h1FF, 9, 3, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("mark_data", 32'(last_data), 32'h1FF);
        check_eq("mark_status", 32'(last_status), 0);
        send_frame(fr, fn, 1); line(20, 1'b1);
        check_eq("mark_glitch_data", 32'(last_data), 32'h1FF);
        check_eq("mark_glitch_status", 32'(last_status), 0);
        check_eq("mark_count", 32'(n_wr), 5);

        // break: line low for 20 bit times
        cfg_data_len = 4'd8; cfg_pri_mod = 3'b000;
        line(20*OSR, 1'b0);
        check_eq("brk_count", 32'(n_wr), 6);
        check_eq("brk_data", 32'(last_data), 0);
        check_eq("brk_status", 32'(last_status), 32'b111);
        check_eq("brk_pulse", 32'(n_brk), 1);
        line(20, 1'b1);
        make_frame(9'h055, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("post_brk_data", 32'(last_data), 32'h055);
        check_eq("post_brk_status", 32'(last_status), 0);
        check_eq("post_brk_count", 32'(n_wr), 7);

        // overflow: fifo full during 0x11, then 0x22 normally
        fifo_aval = 1'b0;
        make_frame(9'h011, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        fifo_aval = 1'b1;
        check_eq("ovr_nowrite", 32'(n_wr), 7);
        check_eq("ovr_pulse", 32'(n_ovr), 1);
        make_frame(9'h022, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("after_ovr_data", 32'(last_data), 32'h022);
        check_eq("after_ovr_count", 32'(n_wr), 8);

        // idle timeout of 4 bit times after 0x41
        cfg_tout_char = 8'd4;
        make_frame(9'h041, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(200, 1'b1);
        check_eq("tout_data", 32'(last_data), 32'h041);
        check_eq("tout_pulse", 32'(n_tout), 1);
        check_eq("tout_delay", 32'(tout_cyc - wr_cyc), 32'(4*OSR));
        line(200, 1'b1);
        check_eq("tout_once", 32'(n_tout), 1);

        // enable dropped mid-frame
        nw = n_wr;
        make_frame(9'h000, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, 4, 0);
        cfg_rx_enable = 1'b0;
        line(5, 1'b1);
        @(negedge clk);
        check_eq("dis_fifo_data", 32'(fifo_data), 0);
        cfg_rx_enable = 1'b1;
        line(200, 1'b1);
        check_eq("dis_nowrite", 32'(n_wr), 32'(nw));
        make_frame(9'h07E, 8, 0, 0, 1, 0, fr, fn);
        send_frame(fr, fn, 0); line(20, 1'b1);
        check_eq("reen_data", 32'(last_data), 32'h07E);
        check_eq("reen_count", 32'(n_wr), 32'(nw + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
